// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = (inA - inB) mod 2^WIDTH, Bout = (inA < inB).
// Operands are processed LSB first through one full-subtractor cell, one bit
// per clock, with valid/ready handshakes on both the operand and result sides.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             Bout
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] d_sh_q, d_sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic [CW-1:0]    count_q, count_d;

  logic             d_bit;
  logic             borrow_nxt;
  logic             last_bit;
  logic [WIDTH-1:0] d_sh_shift;

  // Full-subtractor cell on the current LSBs plus the running borrow.
  assign d_bit      = a_sh_q[0] ^ b_sh_q[0] ^ borrow_q;
  assign borrow_nxt = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & borrow_q);
  assign d_sh_shift = {d_bit, d_sh_q[WIDTH-1:1]};
  assign last_bit   = (count_q == CW'(WIDTH - 1));

  // Next-state and datapath decode for the IDLE/RUN/DONE sequencer.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    d_sh_d   = d_sh_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    count_d  = count_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d   = inA;
          b_sh_d   = inB;
          borrow_d = 1'b0;
          count_d  = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        d_sh_d   = d_sh_shift;
        borrow_d = borrow_nxt;
        count_d  = count_q + 1'b1;
        if (last_bit) begin
          // Publish the complete result only once all WIDTH bits are in.
          diff_d  = d_sh_shift;
          bout_d  = borrow_nxt;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; async reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the shift registers and counter are ordinary flops, so clearing
      // them on reset is cheap and keeps a restart free of stale history.
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      d_sh_q   <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      d_sh_q   <= d_sh_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      count_q  <= count_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign Bout      = bout_q;

endmodule
